led_seq: RTL and testbench

LED_SEQ -- requirements
Module: led_seq

---
 rtl/led_seq.sv | 190 +++++++++++++++++++
 tb/tb_led_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_seq.sv
// led_seq: stepped LED sequencer with pattern, chase, bounce and hold modes.
// A prescaler produces one tick every DIV enabled cycles. Each tick advances
// the sequencer, and leds/wrap are registered on the same edge.
// A new pattern is offered through a one-entry shadow register with a
// valid/ready handshake.
// Optional feature macro: LED_SEQ_BOUNCE_EN enables the real bounce mode.
// Without it, mode 2 behaves exactly like chase.
module led_seq #(
  parameter int                 N_LEDS   = 5,
  parameter int                 PAT_LEN  = 12,
  parameter int                 DIV      = 1200000,
  parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(12'b0000_0000_0101)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               pat_valid,
  input  logic [PAT_LEN-1:0] pat_data,
  output logic               pat_ready,
  output logic [N_LEDS-1:0]  leds,
  output logic               wrap
);

  typedef enum logic [1:0] {M_PAT = 2'd0, M_CHASE = 2'd1, M_BOUNCE = 2'd2, M_HOLD = 2'd3} mode_t;

  localparam int SW = $clog2(PAT_LEN);
  localparam int PW = $clog2(N_LEDS);
  localparam int CW = $clog2(DIV);
  localparam logic [SW-1:0] STEP_MAX = SW'(PAT_LEN - 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(N_LEDS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      step_q, step_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               wrap_q, wrap_d;
  logic               live_q, live_d;   // a mode has been displayed since reset
  mode_t              cur_q, cur_d;     // mode that is currently running
  logic               pend_q, pend_d;   // shadow holds a pattern not yet applied
  logic               ready_q, ready_d;
  logic [PAT_LEN-1:0] shadow_q, shadow_d;
  logic [PAT_LEN-1:0] active_q, active_d;
`ifdef LED_SEQ_BOUNCE_EN
  logic               dir_q, dir_d;     // 1 = moving down
`endif

  logic               tick, chg, apply, xfer;
  mode_t              em;
  logic [PAT_LEN-1:0] pat_sel;

  // Prescaler: counts enabled cycles and ticks on the last one.
  always_comb begin
    tick  = en && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Sequencer next state, LED image and shadow-pattern handshake.
  always_comb begin
    em     = mode_t'(mode);
    chg    = !live_q || (em != cur_q);
    // Pattern mode waits for its own wrap. Every other mode applies on any tick.
    apply  = tick && pend_q && ((em != M_PAT) || (!chg && step_q == STEP_MAX));
    // On the applying wrap tick, step 0 is already shown from the new pattern.
    pat_sel = apply ? shadow_q : active_q;
    xfer   = pat_valid && ready_q;

    step_d   = step_q;
    pos_d    = pos_q;
    leds_d   = leds_q;
    wrap_d   = 1'b0;
    live_d   = live_q;
    cur_d    = cur_q;
`ifdef LED_SEQ_BOUNCE_EN
    dir_d    = dir_q;
`endif
    pend_d   = xfer ? 1'b1 : (apply ? 1'b0 : pend_q);
    shadow_d = xfer ? pat_data : shadow_q;
    active_d = apply ? shadow_q : active_q;
    ready_d  = !pend_q && !xfer;

    if (tick) begin
      if (em == M_HOLD) begin
        // Hold freezes the LEDs. It only rewinds the position for the next mode.
        cur_d = M_HOLD;
        if (chg) begin
          live_d = 1'b1;
          step_d = '0;
          pos_d  = '0;
`ifdef LED_SEQ_BOUNCE_EN
          dir_d  = 1'b0;
`endif
        end
      end else if (chg) begin
        // A new mode starts at position 0 and never pulses wrap.
        live_d = 1'b1;
        cur_d  = em;
        step_d = '0;
        pos_d  = '0;
`ifdef LED_SEQ_BOUNCE_EN
        dir_d  = 1'b0;
`endif
        leds_d = (em == M_PAT) ? {N_LEDS{pat_sel[0]}} : N_LEDS'(1);
      end else begin
        case (em)
          M_PAT: begin
            if (step_q == STEP_MAX) begin
              step_d = '0;
              wrap_d = 1'b1;
            end else begin
              step_d = step_q + SW'(1);
            end
            leds_d = {N_LEDS{pat_sel[step_d]}};
          end
`ifdef LED_SEQ_BOUNCE_EN
          M_BOUNCE: begin
            if (!dir_q) begin
              if (pos_q == POS_MAX) begin
                pos_d = POS_MAX - PW'(1);
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              pos_d = pos_q - PW'(1);
            end
            // Reaching the bottom while moving down ends one bounce period.
            if (dir_d && pos_d == '0) begin
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end
            leds_d = N_LEDS'(1) << pos_d;
          end
`endif
          default: begin
            if (pos_q == POS_MAX) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + PW'(1);
            end
            leds_d = N_LEDS'(1) << pos_d;
          end
        endcase
      end
    end
  end

  // State registers. Reset discards any shadowed pattern.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= '0;
      step_q   <= '0;
      pos_q    <= '0;
      leds_q   <= '0;
      wrap_q   <= 1'b0;
      live_q   <= 1'b0;
      cur_q    <= M_PAT;
      pend_q   <= 1'b0;
      ready_q  <= 1'b1;
      shadow_q <= '0;
      active_q <= PAT_INIT;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
      leds_q   <= leds_d;
      wrap_q   <= wrap_d;
      live_q   <= live_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
`ifdef LED_SEQ_BOUNCE_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign leds      = leds_q;
  assign wrap      = wrap_q;
  assign pat_ready = ready_q;

endmodule

// File: tb/tb_led_seq.sv
// tb_led_seq: directed scoreboard bench for led_seq (DIV=4, 5 LEDs, 12 steps).
module tb_led_seq;
  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        RST, en, pat_valid, pat_ready, wrap;
  logic [1:0]  mode;
  logic [11:0] pat_data;
  logic [4:0]  leds;

  typedef struct {
    logic [4:0] leds;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  led_seq #(.N_LEDS(5), .PAT_LEN(12), .DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .en(en), .mode(mode), .pat_valid(pat_valid),
    .pat_data(pat_data), .pat_ready(pat_ready), .leds(leds), .wrap(wrap)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] l, input logic w);
    exp_t e;
    e.leds = l;
    e.wrap = w;
    sb.push_back(e);
  endtask

  // Starts at #1 after an update edge and ends at #1 after the next one.
  task automatic tick_chk(input string tag, input logic pv = 1'b0, input logic [11:0] pd = '0);
    exp_t e;
    pat_valid = pv;
    pat_data  = pd;
    @(posedge CLK); #1;
    pat_valid = 1'b0;
    chk({tag, "_wrap_low"}, {31'b0, wrap}, 32'd0);
    repeat (DIV - 1) @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty obs=%0h exp=entry", tag, leds);
    end else begin
      e = sb.pop_front();
      chk({tag, "_leds"}, {27'b0, leds}, {27'b0, e.leds});
      chk({tag, "_wrap"}, {31'b0, wrap}, {31'b0, e.wrap});
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick_chk(tag);
  endtask

  initial begin
    logic [11:0] p0;
    p0 = 12'h005;
    RST = 1'b1; en = 1'b1; mode = 2'd0; pat_valid = 1'b0; pat_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_leds",  {27'b0, leds},      32'd0);
    chk("rst_wrap",  {31'b0, wrap},      32'd0);
    chk("rst_ready", {31'b0, pat_ready}, 32'd1);
    RST = 1'b0;

    // Pattern mode with the reset pattern: one full period, then the wrap.
    for (int i = 0; i < 12; i++) push({5{p0[i]}}, 1'b0);
    push(5'h1F, 1'b1);
    run("pat", 13);

    // Load all ones at step 5. The old pattern runs until the wrap.
    for (int i = 1; i <= 5; i++) push({5{p0[i]}}, 1'b0);
    run("pat2", 5);
    push(5'h00, 1'b0);
    tick_chk("ld_s6", 1'b1, 12'hFFF);
    chk("ld_ready_low", {31'b0, pat_ready}, 32'd0);
    for (int i = 7; i <= 11; i++) push(5'h00, 1'b0);
    tick_chk("ld_s7");
    tick_chk("ld_s8_ign", 1'b1, 12'h000);
    run("ld_s9", 3);
    chk("ld_ready_still_low", {31'b0, pat_ready}, 32'd0);
    push(5'h1F, 1'b1);
    tick_chk("ld_wrap");
    push(5'h1F, 1'b0); push(5'h1F, 1'b0);
    run("ld_new", 2);
    chk("ld_ready_high", {31'b0, pat_ready}, 32'd1);

    // Chase mode, with an enable freeze in the middle of a step.
    mode = 2'd1;
    push(5'h01, 1'b0); push(5'h02, 1'b0);
    run("chase", 2);
    push(5'h04, 1'b0);
    repeat (2) @(posedge CLK);
    #1 en = 1'b0;
    repeat (10) @(posedge CLK);
    #1 chk("frz_leds", {27'b0, leds}, 32'h02);
    en = 1'b1;
    @(posedge CLK); #1;
    chk("frz_resume1", {27'b0, leds}, 32'h02);
    @(posedge CLK); #1;
    begin
      exp_t e;
      e = sb.pop_front();
      chk("frz_resume2", {27'b0, leds}, {27'b0, e.leds});
    end
    push(5'h08, 1'b0); push(5'h10, 1'b0); push(5'h01, 1'b1);
    run("chase2", 3);

    // Bounce mode, or chase when bounce is compiled out.
    mode = 2'd2;
`ifdef LED_SEQ_BOUNCE_EN
    push(5'h01, 1'b0); push(5'h02, 1'b0); push(5'h04, 1'b0); push(5'h08, 1'b0);
    push(5'h10, 1'b0); push(5'h08, 1'b0); push(5'h04, 1'b0); push(5'h02, 1'b0);
    push(5'h01, 1'b1);
    run("bounce", 9);
`else
    push(5'h01, 1'b0); push(5'h02, 1'b0); push(5'h04, 1'b0); push(5'h08, 1'b0);
    push(5'h10, 1'b0); push(5'h01, 1'b1);
    run("bounce", 6);
`endif
    push(5'h02, 1'b0);
    run("bounce_pos1", 1);

    // Hold freezes the LEDs. The prescaler keeps ticking through it.
    mode = 2'd3;
    push(5'h02, 1'b0); push(5'h02, 1'b0);
    run("hold", 2);
    mode = 2'd1;
    push(5'h01, 1'b0);
    run("hold_exit", 1);

    // Back to pattern (all ones now), then a load and a reset at step 7.
    mode = 2'd0;
    for (int i = 0; i <= 6; i++) push(5'h1F, 1'b0);
    run("pat3", 7);
    push(5'h1F, 1'b0);
    tick_chk("ld2_s7", 1'b1, 12'hABC);
    chk("ld2_ready_low", {31'b0, pat_ready}, 32'd0);
    #3 RST = 1'b1;
    #1;
    chk("arst_leds",  {27'b0, leds},      32'd0);
    chk("arst_wrap",  {31'b0, wrap},      32'd0);
    chk("arst_ready", {31'b0, pat_ready}, 32'd1);
    mode = 2'd1;
    @(posedge CLK); #1;
    RST = 1'b0;
    // A chase tick would apply a surviving shadow. Pattern must show PAT_INIT.
    push(5'h01, 1'b0);
    run("post_chase", 1);
    mode = 2'd0;
    for (int i = 0; i < 4; i++) push({5{p0[i]}}, 1'b0);
    run("post_pat", 4);
    chk("post_ready", {31'b0, pat_ready}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
